// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared state encoding and constants for the I2C write sequencer
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_REG   = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6
  } seq_state_t;

  localparam logic I2C_WR_BIT         = 1'b0;
  localparam int   DEFAULT_FIFO_DEPTH = 16;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev);
    return {dev, I2C_WR_BIT};
  endfunction

endpackage

// File: rtl/i2c_seq_fifo.sv
// rtl/i2c_seq_fifo.sv - payload byte FIFO; power-of-2 depth so pointers wrap naturally
module i2c_seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push against a full FIFO is dropped even if a pop happens in the same cycle.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// rtl/i2c_write_sequencer.sv - drives a bit-level I2C master through START/addr/reg/payload/STOP writes
// Optional underrun watchdog: I2C_SEQ_UNDERRUN_TIMEOUT_EN
module i2c_write_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_dev_addr,
  input  logic [7:0]       cmd_reg_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       m_tx_data,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_i2c_en,
  input  logic             m_ready,
  input  logic             m_tx_done
);

  seq_state_t       state;
  logic [7:0]       reg_addr_q;
  logic [LEN_W-1:0] remaining;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;

  assign wr_ready = !fifo_full;
  assign fifo_pop = (state == ST_LOAD) && !fifo_empty;

  i2c_seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt;
  logic          stalled;
  logic          underrun_timeout;
  logic          aborted;

  assign stalled          = (state == ST_LOAD) && fifo_empty;
  assign underrun_timeout = stalled && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts only while starved in LOAD; any pop or state change restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stalled && !underrun_timeout) begin
      stall_cnt <= stall_cnt + TW'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign err                = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_tx_data  <= '0;
      m_start    <= 1'b0;
      m_stop     <= 1'b0;
      m_i2c_en   <= 1'b0;
      reg_addr_q <= '0;
      remaining  <= '0;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
      err        <= 1'b0;
      aborted    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            reg_addr_q <= cmd_reg_addr;
            remaining  <= cmd_len;
            m_tx_data  <= addr_byte(cmd_dev_addr);
            m_start    <= 1'b1;
            m_i2c_en   <= 1'b1;
            m_stop     <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
            aborted    <= 1'b0;
`endif
          end
        end

        // Drop start as soon as the master leaves IDLE so it cannot re-trigger.
        ST_START: begin
          if (!m_ready) begin
            m_start <= 1'b0;
            state   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (m_tx_done) begin
            m_tx_data <= reg_addr_q;
            state     <= ST_REG;
          end
        end

        ST_REG, ST_DATA: begin
          if (m_tx_done) begin
            if (remaining != '0) begin
              state <= ST_LOAD;
            end else begin
              m_stop   <= 1'b1;
              m_i2c_en <= 1'b1;
              state    <= ST_STOP;
            end
          end
        end

        // With no data, releasing i2c_en parks the master in HOLD with SCL low.
        ST_LOAD: begin
          if (!fifo_empty) begin
            m_tx_data <= fifo_rdata;
            m_i2c_en  <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            state     <= ST_DATA;
          end else begin
            m_i2c_en <= 1'b0;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
            if (underrun_timeout) begin
              m_stop   <= 1'b1;
              m_i2c_en <= 1'b1;
              aborted  <= 1'b1;
              state    <= ST_STOP;
            end
`endif
          end
        end

        ST_STOP: begin
          if (m_ready) begin
            m_stop    <= 1'b0;
            m_i2c_en  <= 1'b0;
            m_start   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
            if (aborted) err <= 1'b1;
            else         done <= 1'b1;
`else
            done      <= 1'b1;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb/tb_i2c_write_sequencer.sv - directed + randomized bench with a behavioural I2C master responder
module tb_i2c_write_sequencer;

  localparam int FIFO_DEPTH     = 16;
  localparam int LEN_W          = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int BIT_CYC        = 4;
  localparam int START_CYC      = 3;
  localparam int STOP_CYC       = 3;
`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
  localparam int UNDERRUN_WAIT  = 500;
`else
  localparam int UNDERRUN_WAIT  = 5000;
`endif

  localparam int M_IDLE = 0, M_START = 1, M_BIT = 2, M_ACK = 3, M_HOLD = 4, M_STOP = 5, M_LAST = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_dev_addr;
  logic [7:0]       cmd_reg_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       m_tx_data;
  logic             m_start;
  logic             m_stop;
  logic             m_i2c_en;
  logic             m_ready;
  logic             m_tx_done;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int txd_cnt     = 0;

  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] payload_q[$];

  always #5 clk = ~clk;

  i2c_write_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .LEN_W          (LEN_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_len      (cmd_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .m_tx_data    (m_tx_data),
    .m_start      (m_start),
    .m_stop       (m_stop),
    .m_i2c_en     (m_i2c_en),
    .m_ready      (m_ready),
    .m_tx_done    (m_tx_done)
  );

  // Behavioural master: byte latched at start of 8 bit-times, tx_done at the 8th, then an ACK slot.
  int         ms;
  int         mcnt;
  logic [7:0] msh;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms <= M_IDLE; mcnt <= 0; msh <= '0; m_ready <= 1'b1; m_tx_done <= 1'b0;
    end else begin
      m_tx_done <= 1'b0;
      case (ms)
        M_IDLE: if (m_start && m_i2c_en) begin ms <= M_START; mcnt <= START_CYC; m_ready <= 1'b0; end
        M_START: if (mcnt > 1) mcnt <= mcnt - 1;
                 else begin msh <= m_tx_data; ms <= M_BIT; mcnt <= 8 * BIT_CYC; end
        M_BIT: if (mcnt > 1) mcnt <= mcnt - 1;
               else begin m_tx_done <= 1'b1; cap_q.push_back(msh); ms <= M_ACK; mcnt <= BIT_CYC; end
        M_ACK, M_HOLD: if (ms == M_ACK && mcnt > 1) mcnt <= mcnt - 1;
                       else if (m_stop) begin ms <= M_STOP; mcnt <= STOP_CYC; end
                       else if (m_i2c_en) begin msh <= m_tx_data; ms <= M_BIT; mcnt <= 8 * BIT_CYC; end
                       else ms <= M_HOLD;
        M_STOP: if (mcnt > 1) mcnt <= mcnt - 1;
                else begin m_ready <= 1'b1; ms <= M_LAST; end
        default: ms <= M_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (done)      done_cnt <= done_cnt + 1;
    if (err)       err_cnt  <= err_cnt + 1;
    if (m_tx_done) txd_cnt  <= txd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic start_q = 1'b0;
  always @(negedge clk) begin
    if (m_start && !start_q) check("m_start_rise_needs_ready", m_ready, 1);
    start_q <= m_start;
  end

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, wr_ready, busy, done, err, m_start, m_stop, m_i2c_en}, 8'b1100_0000);
    check({tag, "_txdata"}, m_tx_data, 0);
  endtask

  task automatic push_all();
    int guard;
    guard = 0;
    while (pend_q.size() > 0) begin
      logic rdy;
      wr_data  = pend_q[0];
      wr_valid = 1'b1;
      rdy      = wr_ready;
      @(negedge clk);
      if (rdy) begin
        void'(pend_q.pop_front());
        guard = 0;
      end else begin
        guard++;
        if (guard > 20000) begin
          check("push_timeout", pend_q.size(), 0);
          pend_q.delete();
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic issue(input logic [6:0] dev, input logic [7:0] rg, input int len);
    int guard = 0;
    cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
    while (!cmd_ready && guard < 20000) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int guard = 0;
    while (done_cnt == d0 && err_cnt == e0 && guard < 60000) begin @(negedge clk); guard++; end
    check("end_within_budget", guard < 60000, 1);
  endtask

  task automatic compare_wire(input string tag);
    check({tag, "_nbytes"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  // Reference: wire bytes are {dev,W}, reg, then the payload in push order.
  task automatic build_expected(input logic [6:0] dev, input logic [7:0] rg);
    exp_q.delete();
    exp_q.push_back({dev, 1'b0});
    exp_q.push_back(rg);
    foreach (payload_q[i]) exp_q.push_back(payload_q[i]);
  endtask

  task automatic run_txn(input string tag, input logic [6:0] dev, input logic [7:0] rg, input bit preload);
    int d0, t0, e0;
    build_expected(dev, rg);
    cap_q.delete();
    if (preload) begin pend_q = payload_q; push_all(); end
    d0 = done_cnt; t0 = txd_cnt; e0 = err_cnt;
    issue(dev, rg, payload_q.size());
    wait_end(d0, e0);
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_tx_done_cnt"}, txd_cnt - t0, payload_q.size() + 2);
    compare_wire(tag);
  endtask

  task automatic rand_payload(input int len);
    payload_q.delete();
    for (int i = 0; i < len; i++) payload_q.push_back(8'($urandom));
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, g;
    logic [6:0] dev_b;
    logic [7:0] reg_b;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_dev_addr = '0; cmd_reg_addr = '0;
    cmd_len = '0; wr_data = '0; wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    payload_q = '{8'hA5, 8'h3C};
    run_txn("write2", 7'h50, 8'h10, 1'b1);

    // len=0 with a byte waiting: it must stay in the FIFO for the next command.
    pend_q = '{8'h5A}; push_all();
    payload_q.delete();
    run_txn("len0", 7'h68, 8'h75, 1'b0);
    payload_q = '{8'h5A};
    run_txn("len0_fifo_kept", 7'h22, 8'h01, 1'b0);

    // Underrun: len=3 with one byte preloaded.
    rand_payload(3);
    build_expected(7'($urandom), 8'($urandom));
    cap_q.delete();
    pend_q = '{payload_q[0]}; push_all();
    d0 = done_cnt; e0 = err_cnt;
    issue(exp_q[0][7:1], exp_q[1], 3);
    g = 0;
    while (ms != M_HOLD && g < 5000) begin @(negedge clk); g++; end
    check("underrun_hold", ms, M_HOLD);
    check("underrun_bytes_before_hold", cap_q.size(), 3);
    check("underrun_en_low", m_i2c_en, 0);
    repeat (UNDERRUN_WAIT) @(negedge clk);
    check("underrun_still_parked", {ms == M_HOLD, busy, done_cnt == d0}, 3'b111);
    pend_q = '{payload_q[1], payload_q[2]}; push_all();
    wait_end(d0, e0);
    repeat (4) @(negedge clk);
    check("underrun_done", done_cnt - d0, 1);
    compare_wire("underrun");

    // 20-byte stream against a 16-deep FIFO.
    rand_payload(20);
    build_expected(7'($urandom), 8'($urandom));
    cap_q.delete();
    for (int i = 0; i < 16; i++) pend_q.push_back(payload_q[i]);
    push_all();
    check("stream_full_ready_low", wr_ready, 0);
    for (int i = 16; i < 20; i++) pend_q.push_back(payload_q[i]);
    d0 = done_cnt; e0 = err_cnt;
    fork
      push_all();
      begin issue(exp_q[0][7:1], exp_q[1], 20); wait_end(d0, e0); end
      begin
        int w = 0;
        while (!wr_ready && w < 20000) begin @(negedge clk); w++; end
        check("stream_ready_after_first_pop", cap_q.size(), 2);
      end
    join
    repeat (4) @(negedge clk);
    compare_wire("stream");

    // cmd_valid held high across completion.
    rand_payload(1);
    build_expected(7'($urandom), 8'($urandom));
    pend_q = payload_q; push_all();
    cap_q.delete();
    d0 = done_cnt;
    cmd_dev_addr = exp_q[0][7:1]; cmd_reg_addr = exp_q[1]; cmd_len = 8'd1; cmd_valid = 1'b1;
    @(negedge clk);
    dev_b = 7'($urandom); reg_b = 8'($urandom);
    cmd_dev_addr = dev_b; cmd_reg_addr = reg_b; cmd_len = 8'd0;
    g = 0;
    while (!cmd_ready && g < 20000) begin @(negedge clk); g++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_second_accept_after_done", done_cnt - d0, 1);
    compare_wire("held_first");
    payload_q.delete();
    build_expected(dev_b, reg_b);
    cap_q.delete();
    d0 = done_cnt;
    wait_end(d0, err_cnt);
    repeat (4) @(negedge clk);
    compare_wire("held_second");

    // Reset in the middle of the first payload byte.
    rand_payload(4);
    pend_q = payload_q; push_all();
    cap_q.delete();
    issue(7'($urandom), 8'($urandom), 4);
    g = 0;
    while (!(cap_q.size() == 2 && ms == M_BIT) && g < 5000) begin @(negedge clk); g++; end
    check("midbyte_reached", {cap_q.size() == 2, ms == M_BIT}, 2'b11);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("midbyte_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rand_payload(2);
    run_txn("after_reset", 7'($urandom), 8'($urandom), 1'b1);

    for (int k = 0; k < 4; k++) begin
      rand_payload($urandom_range(0, 8));
      run_txn($sformatf("rand%0d", k), 7'($urandom), 8'($urandom), 1'b1);
    end

`ifdef I2C_SEQ_UNDERRUN_TIMEOUT_EN
    rand_payload(2);
    build_expected(7'($urandom), 8'($urandom));
    cap_q.delete();
    pend_q = '{payload_q[0]}; push_all();
    d0 = done_cnt; e0 = err_cnt;
    issue(exp_q[0][7:1], exp_q[1], 2);
    wait_end(d0, e0);
    repeat (4) @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    void'(exp_q.pop_back());
    compare_wire("timeout");
`else
    check("err_never_pulses", err_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
